// File: rtl/screen_reader_pkg.sv
// screen_reader_pkg: Hack screen geometry defaults and scan FSM state encoding shared by the screen reader files
package screen_reader_pkg;
  localparam int SCREEN_BASE = 16384;
  localparam int SCREEN_COLS = 512;
  localparam int SCREEN_ROWS = 256;
  localparam int SCREEN_ADDR_W = 15;
  localparam int WORDS_PER_ROW = SCREEN_COLS / 16;
  localparam int SCREEN_WORDS = SCREEN_ROWS * WORDS_PER_ROW;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, DONE} state_t;
endpackage

// File: rtl/screen_reader_shifter.sv
// screen_reader_shifter: 16-bit word load/shift register with bit counter; ports clk, reset, load+data (capture word), shift (advance one pixel), pix (current bit), last_bit (16th pixel of the word)
module screen_reader_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        shift,
  input  logic [15:0] data,
  output logic        pix,
  output logic        last_bit
);
  logic [15:0] sr;
  logic [3:0]  cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= data;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {1'b0, sr[15:1]};
      cnt <= cnt + 4'd1;
    end
  assign pix      = sr[0];
  assign last_bit = cnt == 4'd15;
endmodule

// File: rtl/screen_reader.sv
// screen_reader: scans the screen RAM region and streams pixels with x/y; ports clk, reset, start, mem_rd/mem_addr/mem_data (1-cycle read), pix_valid/pix_ready/pix/pix_x/pix_y (pixel stream), busy, frame_done
module screen_reader
  import screen_reader_pkg::*;
#(
  parameter int BASE   = SCREEN_BASE,
  parameter int COLS   = SCREEN_COLS,
  parameter int ROWS   = SCREEN_ROWS,
  parameter int ADDR_W = SCREEN_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix,
  output logic [8:0]        pix_x,
  output logic [7:0]        pix_y,
  output logic              busy,
  output logic              frame_done
);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(BASE + ROWS * (COLS / 16) - 1);
  localparam logic [8:0]        XMAX  = 9'(COLS - 1);
  state_t            state, next;
  logic [ADDR_W-1:0] ptr;
  logic [8:0]        x;
  logic [7:0]        y;
  logic              hs, bit0, last_bit;
  screen_reader_shifter u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (state == WAIT),
    .shift   (hs),
    .data    (mem_data),
    .pix     (bit0),
    .last_bit(last_bit)
  );
  assign hs         = pix_valid && pix_ready;
  assign mem_rd     = state == FETCH;
  assign mem_addr   = mem_rd ? ptr : '0;
  assign pix_valid  = state == SHIFT;
  assign pix        = pix_valid & bit0;
  assign pix_x      = x;
  assign pix_y      = y;
  assign busy       = state inside {FETCH, WAIT, SHIFT};
  assign frame_done = state == DONE;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = start ? FETCH : IDLE;
      FETCH:   next = WAIT;
      WAIT:    next = SHIFT;
      SHIFT:   next = (hs && last_bit) ? ((ptr == LAST) ? DONE : FETCH) : SHIFT;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // Pointer and row stay on the final word so y never passes ROWS-1; DONE rewinds everything.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr <= FIRST;
      x   <= '0;
      y   <= '0;
    end else if (state == DONE) begin
      ptr <= FIRST;
      x   <= '0;
      y   <= '0;
    end else if (hs) begin
      x <= (x == XMAX) ? 9'd0 : x + 9'd1;
      if (last_bit && ptr != LAST) begin
        ptr <= ptr + 1'b1;
        if (x == XMAX) y <= y + 8'd1;
      end
    end
endmodule

// File: tb/tb_screen_reader.sv
// tb_screen_reader: directed scan tests of screen_reader with a RAM model and pixel/address scoreboard
module tb_screen_reader;
  localparam int ROWS_TB = 16;
  localparam int NWORDS  = ROWS_TB * 32;
  localparam int NPIX    = NWORDS * 16;
  typedef struct packed {logic p; logic [8:0] x; logic [7:0] y;} px_t;
  logic        clk = 0, reset = 1, start = 0, pix_ready = 1;
  logic        mem_rd, pix_valid, pix, busy, frame_done;
  logic [14:0] mem_addr;
  logic [15:0] mem_data = '0;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] mem [0:32767];
  px_t         pq[$];
  logic [14:0] aq[$];
  int checks = 0, errors = 0, hs_cnt = 0, fd_cnt = 0;
  int h0, f0, n;
  screen_reader #(.ROWS(ROWS_TB)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix(pix),
    .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_frame();
    for (int w = 0; w < NWORDS; w++) aq.push_back(15'(16384 + w));
    for (int yy = 0; yy < ROWS_TB; yy++)
      for (int xx = 0; xx < 512; xx++) begin
        logic [15:0] wd;
        wd = mem[16384 + yy * 32 + xx / 16];
        pq.push_back('{wd[xx % 16], 9'(xx), 8'(yy)});
      end
  endtask
  task automatic poll_px(input logic [8:0] xx, input logic [7:0] yy);
    for (int i = 0; i < 20000 && !(pix_valid && pix_x == xx && pix_y == yy); i++) begin
      @(posedge clk); #1;
    end
  endtask
  always @(negedge clk) if (!reset) begin
    if (mem_rd) begin
      chk("mem_rd expected", 64'(aq.size() > 0), 1);
      if (aq.size() > 0) chk("mem_addr", 64'(mem_addr), 64'(aq.pop_front()));
    end
    if (pix_valid && pix_ready) begin
      hs_cnt++;
      chk("pixel expected", 64'(pq.size() > 0), 1);
      if (pq.size() > 0) chk("pixel", 64'({pix, pix_x, pix_y}), 64'(pq.pop_front()));
    end
    if (frame_done) fd_cnt++;
  end
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[16384] = 16'h0001;
    mem[16415] = 16'h8000;
    #12 chk("reset outputs", {mem_rd, mem_addr, pix_valid, pix, pix_x, pix_y, busy, frame_done}, 0);
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle outputs", {mem_rd, mem_addr, pix_valid, pix, pix_x, pix_y, busy, frame_done}, 0);
    end
    // frame 1: first word, stall, row wrap, completion
    push_frame();
    h0 = hs_cnt; f0 = fd_cnt;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk) chk("first fetch", {mem_rd, mem_addr, busy}, {1'b1, 15'd16384, 1'b1});
    @(negedge clk) chk("wait bubble", pix_valid, 0);
    @(negedge clk) chk("first pixel", {pix_valid, pix, pix_x, pix_y}, {1'b1, 1'b1, 9'd0, 8'd0});
    poll_px(9'd3, 8'd0);
    chk("reach x3", pix_valid && pix_x == 3, 1);
    pix_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall hold", {pix_valid, pix, pix_x, pix_y, mem_rd}, {1'b1, 1'b0, 9'd3, 8'd0, 1'b0});
    end
    @(posedge clk); #1 pix_ready = 1;
    @(posedge clk); #1 chk("resume x", {pix_valid, pix_x}, {1'b1, 9'd4});
    poll_px(9'd511, 8'd0);
    chk("x511 pixel", {pix_valid, pix, pix_x, pix_y}, {1'b1, 1'b1, 9'd511, 8'd0});
    for (int i = 0; i < 100 && !mem_rd; i++) begin @(posedge clk); #1; end
    chk("row1 fetch", {mem_rd, mem_addr}, {1'b1, 15'd16416});
    for (int i = 0; i < 100 && !pix_valid; i++) begin @(posedge clk); #1; end
    chk("row1 first", {pix_valid, pix_x, pix_y}, {1'b1, 9'd0, 8'd1});
    for (int i = 0; i < 20000 && !frame_done; i++) begin @(posedge clk); #1; end
    chk("frame1 done", {frame_done, busy}, {1'b1, 1'b0});
    @(posedge clk); #1 chk("frame1 pulse end", {frame_done, busy}, 0);
    chk("frame1 handshakes", hs_cnt - h0, NPIX);
    chk("frame1 done pulses", fd_cnt - f0, 1);
    chk("frame1 pixels left", pq.size(), 0);
    chk("frame1 reads left", aq.size(), 0);
    // frame 2: exact throughput with start pulses ignored while busy
    push_frame();
    h0 = hs_cnt; f0 = fd_cnt;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk("frame2 fetch", {mem_rd, mem_addr}, {1'b1, 15'd16384});
    n = 0;
    while (!frame_done && n < 20000) begin
      @(posedge clk); #1;
      n++;
      if (n == 1000 || n == 5000) start = 1;
      if (n == 1003 || n == 5001) start = 0;
    end
    chk("frame2 cycles", n, NWORDS * 18);
    chk("frame2 done busy", busy, 0);
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    chk("frame2 idle after", {busy, mem_rd, frame_done}, 0);
    chk("frame2 handshakes", hs_cnt - h0, NPIX);
    chk("frame2 done pulses", fd_cnt - f0, 1);
    chk("frame2 reads left", aq.size(), 0);
    // frame 3: async reset mid-frame, then restart from the base
    push_frame();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    poll_px(9'd200, 8'd10);
    chk("reach x200 y10", {pix_valid, pix_x, pix_y}, {1'b1, 9'd200, 8'd10});
    #2 reset = 1;
    #1 chk("async reset outputs", {mem_rd, mem_addr, pix_valid, pix, pix_x, pix_y, busy, frame_done}, 0);
    pq.delete(); aq.delete();
    @(posedge clk); #1 reset = 0;
    push_frame();
    start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk) chk("restart fetch", {mem_rd, mem_addr}, {1'b1, 15'd16384});
    @(negedge clk);
    @(negedge clk) chk("restart pixel", {pix_valid, pix, pix_x, pix_y}, {1'b1, 1'b1, 9'd0, 8'd0});
    @(posedge clk); #1 reset = 1;
    pq.delete(); aq.delete();
    @(posedge clk); #1 reset = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
